// File: rtl/uart_rx_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_deserializer
// Brief    : UART receive deserializer. Counts rising edges of the 16x
//            oversample square wave as ticks, synchronises rx, validates the
//            start bit, majority-votes bits at counts 7/8/9 and delivers
//            LSB-first words through a valid/ready holding register with
//            frame, parity and overrun flags.
// Options  : define UART_RX_PARITY_EN to add a parity bit between data and
//            stop; PARITY_ODD selects odd (1) or even (0) parity.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_deserializer #(
   parameter int DATA_BITS  = 8,
   parameter int PARITY_ODD = 0
) (
   input  logic                 system_clk,
   input  logic                 reset,
   input  logic                 rxclk_en,
   input  logic                 rx,
   input  logic                 rx_ready,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun_err,
   output logic                 rx_busy
);

   localparam int   BCW        = $clog2(DATA_BITS);
   localparam logic ODD_SENSE  = (PARITY_ODD != 0);
   localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_START    = 3'd1,
      ST_DATA     = 3'd2,
      ST_PARITY   = 3'd3,
      ST_STOP     = 3'd4,
      ST_BRK_WAIT = 3'd5
   } state_t;

   state_t               state;
   logic                 rx_meta;
   logic                 rx_s;
   logic                 rxclk_en_d;
   logic                 tick;
   logic [3:0]           samp_cnt;
   logic [BCW-1:0]       bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 s7;
   logic                 s8;
   logic                 s9;
   logic                 maj_full;
   logic                 maj_stop;
   logic                 can_load;

`ifdef UART_RX_PARITY_EN
   logic                 par_bit;
   logic                 par_err_q;
`endif

   // One-cycle tick on each rising edge of the oversample square wave
   assign tick = rxclk_en & ~rxclk_en_d;

   // Bit value from the three mid-bit samples; the stop bit decides at
   // count 9 itself, so its third vote is the live synchronised line
   assign maj_full = (s7 & s8) | (s7 & s9) | (s8 & s9);
   assign maj_stop = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);

   // A finished frame may load when the register is empty or being drained
   assign can_load = ~rx_valid | rx_ready;

   // Two-flop rx synchroniser and rxclk_en edge register
   always_ff @(posedge system_clk or negedge reset) begin
      if (!reset) begin
         rx_meta    <= 1'b1;
         rx_s       <= 1'b1;
         rxclk_en_d <= 1'b0;
      end else begin
         rx_meta    <= rx;
         rx_s       <= rx_meta;
         rxclk_en_d <= rxclk_en;
      end
   end

   // Receive FSM, mid-bit sampling and the valid/ready holding register
   always_ff @(posedge system_clk or negedge reset) begin
      if (!reset) begin
         state       <= ST_IDLE;
         samp_cnt    <= 4'd0;
         bit_cnt     <= '0;
         shreg       <= '0;
         s7          <= 1'b1;
         s8          <= 1'b1;
         s9          <= 1'b1;
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         frame_err   <= 1'b0;
         overrun_err <= 1'b0;
         rx_busy     <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bit     <= 1'b0;
         par_err_q   <= 1'b0;
`endif
      end else begin
         overrun_err <= 1'b0;

         // Consumer handshake; a same-cycle completion below re-asserts it
         if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end

         if (tick) begin
            if (samp_cnt == 4'd7) s7 <= rx_s;
            if (samp_cnt == 4'd8) s8 <= rx_s;
            if (samp_cnt == 4'd9) s9 <= rx_s;
            samp_cnt <= samp_cnt + 4'd1;

            case (state)
               ST_IDLE: begin
                  if (!rx_s) begin
                     state    <= ST_START;
                     samp_cnt <= 4'd0;
                     rx_busy  <= 1'b1;
                  end
               end

               ST_START: begin
                  if (samp_cnt == 4'd15) begin
                     if (maj_full) begin
                        // Glitch, not a start bit
                        state   <= ST_IDLE;
                        rx_busy <= 1'b0;
                     end else begin
                        state   <= ST_DATA;
                        bit_cnt <= '0;
                     end
                  end
               end

               ST_DATA: begin
                  if (samp_cnt == 4'd15) begin
                     shreg   <= {maj_full, shreg[DATA_BITS-1:1]};
                     bit_cnt <= bit_cnt + BCW'(1);
                     if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state <= ST_PARITY;
`else
                        state <= ST_STOP;
`endif
                     end
                  end
               end

               ST_PARITY: begin
`ifdef UART_RX_PARITY_EN
                  if (samp_cnt == 4'd15) begin
                     par_bit <= maj_full;
                     state   <= ST_STOP;
                  end
`else
                  state   <= ST_IDLE;
                  rx_busy <= 1'b0;
`endif
               end

               ST_STOP: begin
                  // Deciding at count 9 returns early for resync margin
                  if (samp_cnt == 4'd9) begin
                     samp_cnt <= 4'd0;
                     if (can_load) begin
                        rx_data   <= shreg;
                        frame_err <= ~maj_stop;
                        rx_valid  <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        par_err_q <= ((^shreg) ^ par_bit) != ODD_SENSE;
`endif
                     end else begin
                        overrun_err <= 1'b1;
                     end
                     if (maj_stop) begin
                        state   <= ST_IDLE;
                        rx_busy <= 1'b0;
                     end else begin
                        state   <= ST_BRK_WAIT;
                     end
                  end
               end

               ST_BRK_WAIT: begin
                  // Held-low line yields one frame; wait for idle level
                  if (rx_s) begin
                     state   <= ST_IDLE;
                     rx_busy <= 1'b0;
                  end
               end

               default: begin
                  state   <= ST_IDLE;
                  rx_busy <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef UART_RX_PARITY_EN
   assign parity_err = par_err_q;
`else
   // Parity sense has no effect without a parity bit
   assign parity_err = ODD_SENSE & 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/uart_rx_deserializer.md
Name: uart_rx_deserializer

Overview:
UART receive stage directly downstream of the baud rate generator. Consumes the rxclk_en square wave, which toggles at the 16x-oversample rate, and treats each rising edge as one oversample tick. Synchronises the serial rx line, detects and validates start bits, majority-votes each bit, and delivers bytes LSB-first through a valid/ready holding register with frame and overrun error flags.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..9.
PARITY_ODD, 0, parity sense when parity is compiled in: 1 = odd, 0 = even. Ignored otherwise.

Ports:
system_clk  input  1  system clock; all logic on the rising edge.
reset  input  1  asynchronous reset, active-low.
rxclk_en  input  1  16x-oversample square wave from the baud generator; tick = detected rising edge.
rx  input  1  asynchronous serial line; idle high.
rx_ready  input  1  consumer accepts rx_data when high with rx_valid.
rx_data  output  DATA_BITS  received word, LSB = first bit on the line.
rx_valid  output  1  holding register full.
frame_err  output  1  qualifies rx_data; stop bit sampled low.
parity_err  output  1  qualifies rx_data; parity mismatch.
overrun_err  output  1  one-cycle pulse; a completed frame was dropped.
rx_busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, active-low): state IDLE; rx synchroniser flops = 1; rxclk_en edge register = 0; all outputs 0.
- Tick: register rxclk_en into rxclk_en_d; tick = rxclk_en & ~rxclk_en_d. Tick is one system_clk wide. Counters advance only on tick.
- rx passes through a 2-flop synchroniser to give rx_s.
- Per bit: 4-bit sample counter runs 0..15. Capture rx_s at counts 7, 8 and 9. Bit value = majority of the 3 samples.
- IDLE: on a tick with rx_s = 0, go to START and set the counter to 0.
- START: at count 15, if the majority is 1 (false start), return to IDLE with no output. Otherwise go to DATA with bit_cnt = 0.
- DATA: at count 15, shift the majority bit into the shift register LSB-first. After DATA_BITS bits, go to PARITY if compiled in, else to STOP.
- STOP: at count 9, the frame completes and the following happen on that tick:
  - load rx_data, frame_err = ~majority, and parity_err;
  - set rx_valid;
  - next state = IDLE if the stop bit was 1, else BRK_WAIT.
- Early return at count 9 gives half a bit of resync margin.
- BRK_WAIT: stay until a tick with rx_s = 1, then go to IDLE. A held-low line (break) therefore produces exactly one frame.
- Handshake:
  - rx_valid & rx_ready clears rx_valid on the next cycle.
  - rx_data, frame_err and parity_err hold while rx_valid = 1.
- Completion while rx_valid = 1 and rx_ready = 0: the new frame is discarded, the held data is unchanged, and overrun_err pulses for 1 cycle.
- Completion in the same cycle as acceptance: the new frame loads, rx_valid stays 1, no overrun.
- Latency: rx_valid rises 1 system_clk after the tick at stop-bit count 9.
- Reset mid-frame: aborts immediately and all outputs clear; no partial frame is delivered.

Optional Feature:
UART_RX_PARITY_EN
- Defined: adds a PARITY state between DATA and STOP, one bit time long, majority-sampled. parity_err = (XOR of data bits ^ parity bit) != PARITY_ODD, latched with rx_data.
- Undefined: no PARITY state; DATA goes directly to STOP; parity_err is tied to 0.

Test Plan:
1. rxclk_en toggling every 27 clocks (54-clock tick period, 864 clocks/bit); send 0x55 as 8N1 with rx_ready = 1 -> one rx_valid pulse, rx_data = 0x55, frame_err = 0, rx_busy low afterwards.
2. rx low for 3 ticks, then high -> START aborts at count 15, no rx_valid, state back in IDLE, rx_busy drops.
3. rx held low for 20 bit times -> exactly one frame: rx_data = 0x00, frame_err = 1; no further rx_valid until rx returns high; then 0x3C is received cleanly.
4. rx_ready = 0; send 0xA5 then 0x3C back-to-back -> rx_data stays 0xA5 with rx_valid held; overrun_err pulses once at the second stop; rx_ready = 1 clears rx_valid on the next cycle.
5. Reset asserted during data bit 4 of 0xFF -> all outputs 0 asynchronously; release, send 0x81 -> rx_data = 0x81, no errors.
6. With UART_RX_PARITY_EN and PARITY_ODD = 0: 0x07 with parity bit 1 -> parity_err = 0; 0x07 with parity bit 0 -> parity_err = 1, rx_data = 0x07.
